decoder_seq: RTL and testbench
==============================

// Module: decoder_seq
// PURPOSE
//   Parametrised, registered binary-to-one-hot decoder with valid/ready output handshake.
//   DIRECT mode decodes an address on the input handshake.
//   SCAN mode walks a single one through every output, wrapping at OUT_W-1.
//   Keeps the en-gated zero-output semantics of the combinational 10-to-1024 decoder.
//   Drives one-hot selects (bank/row enables, channel strobes) into downstream datapaths.
// PARAMETERS
//   ADDR_W  10    address width
//   OUT_W   1024  one-hot output width; legal range 2..2**ADDR_W
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       synchronous reset, active low
//   en         in   1       enable; 0 stalls the block and masks outputs
//   mode       in   1       0 = DIRECT, 1 = SCAN
//   in_valid   in   1       address valid (DIRECT only)
//   in_ready   out  1       address accepted when in_valid && in_ready
//   in         in   ADDR_W  binary address
//   out_valid  out  1       y/idx valid
//   out_ready  in   1       consumer accepts when out_valid && out_ready
//   y          out  OUT_W   one-hot output
//   idx        out  ADDR_W  binary index of the set bit in y
//   oor_err    out  1       1-cycle pulse: DIRECT address >= OUT_W was dropped
//   scan_wrap  out  1       1-cycle pulse: SCAN loaded index OUT_W-1
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge, overrides everything):
//     y_q=0, idx_q=0, vld_q=0, cnt=0, mode_q=0, oor_err=0, scan_wrap=0.
//   Port masking: y = en ? y_q : 0; out_valid = en & vld_q; idx = idx_q (unmasked).
//   slot_free = !vld_q || out_ready. in_ready = en && !mode && slot_free.
//   en=0: no accept, no scan step, no pulses; all registers hold.
//     Re-asserting en re-presents the held output unchanged.
//   DIRECT, on accept:
//     in < OUT_W: y_q <= 1<<in, idx_q <= in, vld_q <= 1. Latency 1 clk.
//     in >= OUT_W: y_q/idx_q hold; oor_err <= 1 for one cycle.
//       vld_q <= 0 if it was being consumed this cycle, else holds.
//   DIRECT, no accept: vld_q <= 0 if out_ready is high this cycle; y_q holds.
//   SCAN: in_ready=0; in is ignored. Each cycle with en && slot_free:
//     y_q <= 1<<cnt, idx_q <= cnt, vld_q <= 1.
//     cnt <= (cnt==OUT_W-1) ? 0 : cnt+1.
//     scan_wrap <= (cnt==OUT_W-1).
//     Result: one index per cycle at full throughput.
//   Mode entry: mode_q registers mode every cycle, even with en=0.
//     mode=1 && mode_q=0: cnt is treated as 0 for this cycle's load (scan restarts at 0).
//     SCAN->DIRECT: the held output stays valid until consumed.
//   Back-pressure (en=1, vld_q=1, out_ready=0): y_q, idx_q, cnt frozen; in_ready=0.
//   oor_err and scan_wrap are registered, never stretched, and cleared by reset.
//   cnt width: ADDR_W bits; wraps at OUT_W-1, not at 2**ADDR_W-1.
// STRUCTURE
//   decoder_defs.vh: MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
//   Sub-module onehot_decode #(ADDR_W,OUT_W): combinational.
//     addr -> onehot[OUT_W-1:0] plus in_range flag.
//     Used for both the DIRECT and SCAN paths via a mux on the address.
//   Top level: handshake/valid register, scan counter, mode edge detect, pulse flops.
// TESTING
//   1 Reset: rst_n=0 for 2 clks, en=1, in_valid=1
//       -> y=0, out_valid=0, idx=0, oor_err=0, scan_wrap=0.
//   2 DIRECT: en=1, mode=0, in=3, in_valid=1, out_ready=1
//       -> next clk y=8 (bit 3), idx=3, out_valid=1.
//       Then in=2 -> y=4.
//   3 Enable: en=0 with in=3 valid -> in_ready=0, y=0, out_valid=0.
//       en=1 -> y=8, idx=3 held value re-presented, no new accept lost.
//   4 Back-pressure: out_valid=1 with idx=2, out_ready=0, in=5 valid
//       -> in_ready=0, y stays bit 2.
//       out_ready=1 -> accept, next clk y=bit 5.
//   5 OUT_W=1000 instance: in=1000 accepted
//       -> oor_err high exactly 1 clk, y/idx unchanged.
//       in=999 -> y=bit 999.
//   6 SCAN: mode 0->1, out_ready=1 -> idx 0,1,2,... per clk.
//       At the idx=1023 load scan_wrap pulses once; next idx=0.
//       out_ready=0 at idx=7 holds idx=7 for the stall.
//       Mid-scan rst_n=0 -> all cleared next clk.

Source files
------------

// File: rtl/decoder_seq_pkg.sv
// Shared definitions for the registered one-hot decoder: mode encoding.
package decoder_seq_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

endpackage

// File: rtl/decoder_seq_onehot_decode.sv
// Combinational binary-to-one-hot decode with an in-range flag for widths
// that are not a power of two.
module onehot_decode #(
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 1024
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [OUT_W-1:0]  onehot,
  output logic              in_range
);

  // One extra bit so OUT_W == 2**ADDR_W still compares correctly.
  assign in_range = ({1'b0, addr} < (ADDR_W+1)'(OUT_W));

  always_comb begin
    onehot = '0;
    if (in_range) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with valid/ready output handshake, supporting
// direct address decode and a free-running scan that walks one bit across y.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  y,
  output logic [ADDR_W-1:0] idx,
  output logic              oor_err,
  output logic              scan_wrap
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_W - 1);

  logic [OUT_W-1:0]  y_q;
  logic [ADDR_W-1:0] idx_q;
  logic              vld_q;
  logic [ADDR_W-1:0] cnt;
  mode_e             mode_q;
  mode_e             mode_sel;

  logic              slot_free;
  logic              accept;
  logic              scan_entry;
  logic              scan_last;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] dec_addr;
  logic [OUT_W-1:0]  dec_onehot;
  logic              dec_in_range;

  assign mode_sel   = mode_e'(mode);
  assign slot_free  = !vld_q || out_ready;
  assign in_ready   = en && (mode_sel == MODE_DIRECT) && slot_free;
  assign accept     = in_valid && in_ready;

  // Entering scan restarts the walk at index 0 on the very first load.
  assign scan_entry = (mode_sel == MODE_SCAN) && (mode_q == MODE_DIRECT);
  assign scan_addr  = scan_entry ? '0 : cnt;
  assign scan_last  = (scan_addr == LAST_IDX);
  assign dec_addr   = (mode_sel == MODE_SCAN) ? scan_addr : in;

  onehot_decode #(
    .ADDR_W (ADDR_W),
    .OUT_W  (OUT_W)
  ) u_decode (
    .addr     (dec_addr),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      cnt       <= '0;
      mode_q    <= MODE_DIRECT;
      oor_err   <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      mode_q    <= mode_sel;
      oor_err   <= 1'b0;
      scan_wrap <= 1'b0;
      if (en) begin
        if (mode_sel == MODE_SCAN) begin
          if (slot_free) begin
            y_q       <= dec_onehot;
            idx_q     <= scan_addr;
            vld_q     <= 1'b1;
            cnt       <= scan_last ? '0 : scan_addr + ADDR_W'(1);
            scan_wrap <= scan_last;
          end
        end else if (accept) begin
          if (dec_in_range) begin
            y_q   <= dec_onehot;
            idx_q <= in;
            vld_q <= 1'b1;
          end else begin
            // Out-of-range addresses are dropped; only the pulse reports them.
            oor_err <= 1'b1;
            if (out_ready) vld_q <= 1'b0;
          end
        end else if (out_ready) begin
          vld_q <= 1'b0;
        end
      end
    end
  end

  assign y         = en ? y_q : '0;
  assign out_valid = en & vld_q;
  assign idx       = idx_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq: a negedge scoreboard tracks every
// load, plus directed checks for masking, back-pressure, range and scan wrap.
module tb_decoder_seq;

  localparam int ADDR_W  = 10;
  localparam int OUT_W   = 1024;
  localparam int W_OUT_W = 1000;
  localparam int CW      = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              en;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  y;
  logic [ADDR_W-1:0] idx;
  logic              oor_err;
  logic              scan_wrap;

  logic               w_mode;
  logic               w_in_valid;
  logic               w_in_ready;
  logic [ADDR_W-1:0]  w_in;
  logic               w_out_valid;
  logic               w_out_ready;
  logic [W_OUT_W-1:0] w_y;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_oor_err;
  logic               w_scan_wrap;

  decoder_seq #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .idx       (idx),
    .oor_err   (oor_err),
    .scan_wrap (scan_wrap)
  );

  decoder_seq #(.ADDR_W(ADDR_W), .OUT_W(W_OUT_W)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (w_mode),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in        (w_in),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .y         (w_y),
    .idx       (w_idx),
    .oor_err   (w_oor_err),
    .scan_wrap (w_scan_wrap)
  );

  int check_count = 0;
  int error_count = 0;

  task automatic checkOutput(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] oh(input int i);
    logic [CW-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic applyStimulus(input logic e, input logic m, input logic v,
                               input logic [ADDR_W-1:0] a, input logic r);
    en        = e;
    mode      = m;
    in_valid  = v;
    in        = a;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Scoreboard: expected indices queued as loads happen, popped on consume.
  int   exp_q[$];
  logic mode_prev;
  logic exp_wrap;
  int   scan_exp;
  logic m_slot;
  int   m_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mode_prev = 1'b0;
      exp_wrap  = 1'b0;
      scan_exp  = 0;
    end else begin
      checkOutput("mon_wrap", CW'(scan_wrap), CW'(exp_wrap));
      checkOutput("mon_oor", CW'(oor_err), '0);
      m_slot = (exp_q.size() == 0) || out_ready;
      checkOutput("mon_in_ready", CW'(in_ready), CW'(en && !mode && m_slot));
      exp_wrap = 1'b0;
      if (!en) begin
        checkOutput("mon_masked_valid", CW'(out_valid), '0);
        checkOutput("mon_masked_y", y, '0);
      end else begin
        checkOutput("mon_valid", CW'(out_valid), CW'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          checkOutput("mon_idx", CW'(idx), CW'(exp_q[0]));
          checkOutput("mon_y", y, oh(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
        if (mode) begin
          if (m_slot) begin
            m_v = mode_prev ? scan_exp : 0;
            exp_q.push_back(m_v);
            scan_exp = (m_v == OUT_W - 1) ? 0 : m_v + 1;
            exp_wrap = (m_v == OUT_W - 1);
          end
        end else if (in_valid && m_slot) begin
          exp_q.push_back(int'(in));
        end
      end
      mode_prev = mode;
    end
  end

  bit found;

  initial begin
    rst_n       = 1'b0;
    w_mode      = 1'b0;
    w_in_valid  = 1'b0;
    w_in        = '0;
    w_out_ready = 1'b1;
    found       = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd3, 1'b1);
    repeat (2) tick();
    checkOutput("rst_y", y, '0);
    checkOutput("rst_valid", CW'(out_valid), '0);
    checkOutput("rst_idx", CW'(idx), '0);
    checkOutput("rst_oor", CW'(oor_err), '0);
    checkOutput("rst_wrap", CW'(scan_wrap), '0);
    rst_n = 1'b1;

    $display("[TB] direct decode");
    tick();
    checkOutput("dir_y3", y, oh(3));
    checkOutput("dir_idx3", CW'(idx), CW'(3));
    checkOutput("dir_valid", CW'(out_valid), CW'(1));
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd2, 1'b1);
    tick();
    checkOutput("dir_y2", y, oh(2));
    checkOutput("dir_idx2", CW'(idx), CW'(2));
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd3, 1'b1);
    tick();
    checkOutput("dir_y3b", y, oh(3));

    $display("[TB] enable masking");
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd3, 1'b1);
    checkOutput("en0_in_ready", CW'(in_ready), '0);
    checkOutput("en0_y", y, '0);
    checkOutput("en0_valid", CW'(out_valid), '0);
    tick();
    checkOutput("en0_y_hold", y, '0);
    checkOutput("en0_idx_hold", CW'(idx), CW'(3));
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd2, 1'b1);
    checkOutput("en1_y", y, oh(3));
    checkOutput("en1_idx", CW'(idx), CW'(3));
    checkOutput("en1_valid", CW'(out_valid), CW'(1));
    tick();
    checkOutput("en1_next_y", y, oh(2));
    checkOutput("en1_next_idx", CW'(idx), CW'(2));

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd5, 1'b0);
    checkOutput("bp_in_ready", CW'(in_ready), '0);
    checkOutput("bp_y", y, oh(2));
    repeat (2) begin
      tick();
      checkOutput("bp_y_hold", y, oh(2));
      checkOutput("bp_valid_hold", CW'(out_valid), CW'(1));
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd5, 1'b1);
    checkOutput("bp_release_ready", CW'(in_ready), CW'(1));
    tick();
    checkOutput("bp_y5", y, oh(5));
    checkOutput("bp_idx5", CW'(idx), CW'(5));
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 1'b1);
    tick();
    checkOutput("drain_valid", CW'(out_valid), '0);

    $display("[TB] out-of-range on OUT_W=1000");
    w_in_valid = 1'b1;
    w_in       = 10'd5;
    #1;
    checkOutput("w_in_ready", CW'(w_in_ready), CW'(1));
    tick();
    checkOutput("w_y5", CW'(w_y), oh(5));
    checkOutput("w_idx5", CW'(w_idx), CW'(5));
    checkOutput("w_valid5", CW'(w_out_valid), CW'(1));
    w_in = 10'd1000;
    tick();
    checkOutput("w_oor_pulse", CW'(w_oor_err), CW'(1));
    checkOutput("w_oor_idx", CW'(w_idx), CW'(5));
    checkOutput("w_oor_y", CW'(w_y), oh(5));
    checkOutput("w_oor_valid", CW'(w_out_valid), '0);
    w_in = 10'd999;
    tick();
    checkOutput("w_oor_cleared", CW'(w_oor_err), '0);
    checkOutput("w_y999", CW'(w_y), oh(999));
    checkOutput("w_idx999", CW'(w_idx), CW'(999));
    checkOutput("w_valid999", CW'(w_out_valid), CW'(1));
    w_in_valid = 1'b0;
    tick();
    checkOutput("w_idle_oor", CW'(w_oor_err), '0);
    checkOutput("w_idle_valid", CW'(w_out_valid), '0);

    $display("[TB] scan mode");
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("scan_idx", CW'(idx), CW'(i));
      checkOutput("scan_valid", CW'(out_valid), CW'(1));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 1'b0);
    repeat (3) begin
      tick();
      checkOutput("scan_stall_idx", CW'(idx), CW'(7));
      checkOutput("scan_stall_valid", CW'(out_valid), CW'(1));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 1'b1);
    tick();
    checkOutput("scan_resume_idx", CW'(idx), CW'(8));
    for (int k = 0; k < 1100 && !found; k++) begin
      tick();
      if (scan_wrap) found = 1'b1;
    end
    checkOutput("scan_wrap_seen", CW'(found), CW'(1));
    if (found) checkOutput("scan_wrap_idx", CW'(idx), CW'(OUT_W - 1));
    tick();
    checkOutput("scan_after_wrap_idx", CW'(idx), '0);
    checkOutput("scan_after_wrap_pulse", CW'(scan_wrap), '0);
    repeat (3) tick();

    $display("[TB] mid-scan reset");
    rst_n = 1'b0;
    tick();
    checkOutput("mrst_y", y, '0);
    checkOutput("mrst_valid", CW'(out_valid), '0);
    checkOutput("mrst_idx", CW'(idx), '0);
    checkOutput("mrst_wrap", CW'(scan_wrap), '0);
    checkOutput("mrst_oor", CW'(oor_err), '0);
    rst_n = 1'b1;
    repeat (4) tick();
    checkOutput("post_rst_scan_idx", CW'(idx), CW'(3));

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
